// File: rtl/fcvt_int_to_fp.sv
// int64/uint64 to IEEE-754 double: 6-step leading-zero normaliser, then round-to-nearest-even.
// Result valid 7 clocks after accept; held in DONE until out_ready, one operand in flight.
module fcvt_int_to_fp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] fp_out,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] mag;
    logic [6:0]  exp_cnt;
    logic [2:0]  step;
    logic        sign;

    logic [6:0]  k;
    logic        top_zero;
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        round_up;
    logic [52:0] mant_sum;
    logic [6:0]  exp_adj;
    logic [10:0] exp_bias;
    logic        neg_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)     next_state = NORM;
            NORM:    if (step == 3'd0) next_state = ROUND;
            ROUND:                     next_state = DONE;
            DONE:    if (out_ready)    next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
    end

    // Shift by 2^step whenever the top 2^step bits are all zero.
    always_comb begin
        k        = 7'd1 << step;
        top_zero = ((mag >> (7'd64 - k)) == 64'd0);
    end

    always_comb begin
        guard    = mag[10];
        sticky   = |mag[9:0];
        lsb      = mag[11];
        round_up = guard & (sticky | lsb);
        mant_sum = {1'b0, mag[62:11]} + {52'd0, round_up};
        exp_adj  = exp_cnt + {6'd0, mant_sum[52]};
        exp_bias = {4'd0, exp_adj} + 11'd1023;
        neg_in   = in_signed & in_data[63];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag     <= 64'd0;
            exp_cnt <= 7'd0;
            step    <= 3'd0;
            sign    <= 1'b0;
            fp_out  <= 64'd0;
            inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign    <= neg_in;
                        mag     <= neg_in ? (~in_data + 64'd1) : in_data;
                        exp_cnt <= 7'd63;
                        step    <= 3'd5;
                    end
                end
                NORM: begin
                    if (top_zero) begin
                        mag     <= mag << k;
                        exp_cnt <= exp_cnt - k;
                    end
                    if (step != 3'd0) begin
                        step <= step - 3'd1;
                    end
                end
                ROUND: begin
                    // A zero operand reaches here fully shifted with mag still zero.
                    if (mag == 64'd0) begin
                        fp_out  <= 64'd0;
                        inexact <= 1'b0;
                    end else begin
                        fp_out  <= {sign, exp_bias, mant_sum[51:0]};
                        inexact <= guard | sticky;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcvt_int_to_fp.sv
// Scoreboard bench for fcvt_int_to_fp: directed corner values, stall, mid-operation reset, streaming.
module tb_fcvt_int_to_fp;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic        inexact;

    int checks = 0;
    int errors = 0;
    logic [64:0] sb[$];

    fcvt_int_to_fp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_out    (fp_out),
        .inexact   (inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: locate the MSB, truncate to 53 bits, compare the remainder against one half.
    function automatic logic [64:0] model(input logic [63:0] d, input logic s);
        logic        sg;
        logic [63:0] v;
        logic [63:0] m;
        logic [63:0] rem;
        logic [63:0] half;
        logic        up;
        logic [10:0] e;
        int          p;
        sg  = s & d[63];
        v   = sg ? (~d + 64'd1) : d;
        rem = 64'd0;
        if (v == 64'd0) return 65'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (v[i]) p = i;
        if (p <= 52) begin
            m = v << (52 - p);
        end else begin
            m    = v >> (p - 52);
            rem  = v & ((64'd1 << (p - 52)) - 64'd1);
            half = 64'd1 << (p - 53);
            up   = (rem > half) || ((rem == half) && m[0]);
            m    = m + {63'd0, up};
            if (m[53]) begin
                m = m >> 1;
                p = p + 1;
            end
        end
        e = 11'(p + 1023);
        return {sg, e, m[51:0], rem != 64'd0};
    endfunction

    task automatic convert(input logic [63:0] d, input logic s, input logic [64:0] expv,
                           input string name);
        int wait_cnt;
        int lat;
        logic [64:0] got;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        wait_cnt  = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
            errors++;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 7) begin
            $display("FAIL %s latency: got %0d required 7", name, lat);
            errors++;
        end
        got = sb.pop_front();
        checks++;
        if ({fp_out, inexact} !== got) begin
            $display("FAIL %s result: fp_out=%h inexact=%b required fp_out=%h inexact=%b",
                     name, fp_out, inexact, got[64:1], got[0]);
            errors++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1",
                     name, out_valid, in_ready);
            errors++;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || fp_out !== 64'd0 || inexact !== 1'b0) begin
            $display("FAIL reset_state: out_valid=%b in_ready=%b fp_out=%h inexact=%b required 0/0/0/0",
                     out_valid, in_ready, fp_out, inexact);
            errors++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
            errors++;
        end
    endtask

    task automatic test_directed;
        convert(64'd1,                  1'b1, {64'h3FF0000000000000, 1'b0}, "signed_one");
        convert(64'hFFFFFFFFFFFFFFFF,   1'b1, {64'hBFF0000000000000, 1'b0}, "signed_minus_one");
        convert(64'd0,                  1'b1, {64'h0000000000000000, 1'b0}, "zero_signed");
        convert(64'd0,                  1'b0, {64'h0000000000000000, 1'b0}, "zero_unsigned");
        convert(64'h8000000000000000,   1'b1, {64'hC3E0000000000000, 1'b0}, "int_min");
        convert(64'hFFFFFFFFFFFFFFFF,   1'b0, {64'h43F0000000000000, 1'b1}, "umax_carry");
        convert(64'h0020000000000001,   1'b0, {64'h4340000000000000, 1'b1}, "tie_even");
        convert(64'h0020000000000003,   1'b0, {64'h4340000000000002, 1'b1}, "tie_round_up");
        convert(64'h8000000000000000,   1'b0, {64'h43E0000000000000, 1'b0}, "u_two_pow_63");
        convert(64'd42,                 1'b0, {64'h4045000000000000, 1'b0}, "forty_two");
    endtask

    task automatic test_handshake;
        int lat;
        logic [64:0] held;
        logic [64:0] got;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 64'h0020000000000003;
        in_signed = 1'b0;
        @(posedge clk);
        sb.push_back({64'h4340000000000002, 1'b1});
        @(negedge clk);
        in_data   = 64'd5;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        held = sb[0];
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {fp_out, inexact} !== held) begin
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b fp_out=%h inexact=%b required 1/0/%h/%b",
                         i, out_valid, in_ready, fp_out, inexact, held[64:1], held[0]);
                errors++;
            end
            @(negedge clk);
        end
        got = sb.pop_front();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL stall_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
            errors++;
        end
        @(posedge clk);
        sb.push_back({64'h4014000000000000, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 7) begin
            $display("FAIL stall_next_latency: got %0d required 7 (got entry %h)", lat, got);
            errors++;
        end
        got = sb.pop_front();
        checks++;
        if ({fp_out, inexact} !== got) begin
            $display("FAIL stall_next_result: fp_out=%h inexact=%b required %h/%b",
                     fp_out, inexact, got[64:1], got[0]);
            errors++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 64'd123456789;
        in_signed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fp_out !== 64'd0 || inexact !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL reset_mid: out_valid=%b fp_out=%h inexact=%b in_ready=%b required 0/0/0/0",
                     out_valid, fp_out, inexact, in_ready);
            errors++;
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 0) begin
            $display("FAIL reset_mid_stale: out_valid cycles=%0d required 0", seen);
            errors++;
        end
        convert(64'd42, 1'b1, {64'h4045000000000000, 1'b0}, "after_reset_42");
    endtask

    task automatic test_random;
        logic [63:0] d;
        logic        s;
        for (int i = 0; i < 12; i++) begin
            d = {$urandom, $urandom} >> $urandom_range(0, 63);
            s = 1'($urandom_range(0, 1));
            convert(d, s, model(d, s), "random");
        end
    endtask

    task automatic test_back_to_back;
        int accepted;
        int done;
        int cyc;
        int last_acc;
        logic adv;
        logic [64:0] got;
        accepted = 0;
        done     = 0;
        cyc      = 0;
        last_acc = -1;
        adv      = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = {$urandom, $urandom};
        in_signed = 1'($urandom_range(0, 1));
        while (done < 8 && cyc < 300) begin
            if (adv) begin
                if (accepted == 8) begin
                    in_valid = 1'b0;
                end else begin
                    in_data   = {$urandom, $urandom} >> $urandom_range(0, 40);
                    in_signed = 1'($urandom_range(0, 1));
                end
                adv = 1'b0;
            end
            if (out_valid) begin
                got = sb.pop_front();
                checks++;
                if ({fp_out, inexact} !== got) begin
                    $display("FAIL b2b_result[%0d]: fp_out=%h inexact=%b required %h/%b",
                             done, fp_out, inexact, got[64:1], got[0]);
                    errors++;
                end
                done++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, in_signed));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 9) begin
                        $display("FAIL b2b_spacing: got %0d cycles required 9", cyc - last_acc);
                        errors++;
                    end
                end
                last_acc = cyc;
                accepted++;
                adv = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (done !== 8) begin
            $display("FAIL b2b_count: completed %0d required 8", done);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcvt_int_to_fp.md
# fcvt_int_to_fp

Multi-cycle int64/uint64 → IEEE-754 double converter for the FPU conversion path (FCVT.D.L / FCVT.D.LU). It is the inverse-direction companion of the combinational double→int64 converter. It produces the double-precision operands that downstream FP stages, including that converter, consume. Normalization uses a fixed 6-step leading-zero shifter with round-to-nearest-even, behind valid/ready handshakes on both sides.

## Interface
Parameters: none (widths fixed: 64-bit integer in, 64-bit double out).
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream offers an operand
- in_ready  output  1  block can accept an operand
- in_data  input  64  integer operand
- in_signed  input  1  1 = two's-complement int64, 0 = uint64; sampled with in_data
- out_valid  output  1  fp_out/inexact hold a result
- out_ready  input  1  downstream accepts result
- fp_out  output  64  double result {sign, exp[10:0], mant[51:0]}
- inexact  output  1  result was rounded (guard|sticky nonzero)

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch sign = in_signed & in_data[63];
  - latch mag = sign ? -in_data : in_data, as 64-bit unsigned (−2^63 gives 0x8000_0000_0000_0000);
  - set exp_cnt = 63 (7 bits), step = 5; go to NORM.
- NORM (exactly 6 cycles, step 5→0): let k = 2^step. If mag[63:64-k] == 0, mag <<= k and exp_cnt -= k. Decrement step; after step 0, go to ROUND. If mag == 0, all steps shift and the zero flag is used in ROUND.
- ROUND (1 cycle):
  - mant = mag[62:11], guard = mag[10], sticky = |mag[9:0], lsb = mag[11];
  - round up iff guard & (sticky | lsb);
  - if round-up carries out of mant (mant all ones), mant = 0 and exp_cnt += 1;
  - biased exponent = exp_cnt + 1023 (11 bits; range 1023..1087, never overflows);
  - fp_out = {sign, biased_exp, mant}; inexact = guard | sticky;
  - zero input: fp_out = 0x0000000000000000, inexact = 0, sign forced 0;
  - go to DONE.
- DONE: out_valid=1, and fp_out/inexact stay stable. On out_ready, go to IDLE. in_ready=0 in all states except IDLE.
- in_data/in_signed are don't-care outside the accept cycle.
- One operand in flight; no input buffering.

## Timing
- Reset:
  - while rst_n=0 at a rising edge, state→IDLE;
  - fp_out, inexact, out_valid, internal mag/exp_cnt/step/sign all → 0;
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-operation (NORM/ROUND/DONE) aborts the conversion. No result is emitted, and out_valid is 0 the cycle after the reset edge.
- Latency: accept at edge A; NORM on edges A+1..A+6; ROUND on A+7; out_valid=1 in the cycle following A+7 (7 clocks after accept).
- With out_ready held high, the result is consumed at edge A+8 and state returns to IDLE. The next operand is accepted at A+9, so throughput is 1 per 9 cycles.
- out_ready low stalls in DONE indefinitely with outputs held.
- Asserting out_ready outside DONE has no effect.
- in_valid outside IDLE is ignored, and the operand must be held by upstream until in_ready.

## Test plan
- Signed 1 → fp_out=0x3FF0000000000000, inexact=0, out_valid 7 clocks after accept. Signed −1 (0xFFFF…FF) → 0xBFF0000000000000.
- Zero (signed and unsigned) → 0x0000000000000000, inexact=0. Signed 0x8000000000000000 (−2^63) → 0xC3E0000000000000, inexact=0.
- Unsigned 0xFFFFFFFFFFFFFFFF → mantissa carry-out, 0x43F0000000000000, inexact=1. The same value signed → 0xBFF0000000000000.
- RNE ties: unsigned 2^53+1 → 0x4340000000000000, inexact=1 (tie to even, no increment). 2^53+3 → 0x4340000000000002, inexact=1 (round up).
- Handshake:
  - hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, and a second in_valid is not accepted;
  - then out_ready=1 → IDLE, and the next operand is accepted the following edge.
- Assert rst_n=0 during NORM step 3 → next cycle state IDLE, out_valid=0, fp_out=0, no stale result emitted after release. A fresh operand 42 → 0x4045000000000000.
